exec_shift_right_seq: RTL and testbench

//  Iterative right shifter for the execute stage. Serves SRL/SRA/SRLV/SRAV as
//  the right-direction counterpart of the stage's left shifting.

---
 rtl/exec_pkg.sv | 33 +++
 rtl/shift_right_step.sv | 21 ++
 rtl/exec_shift_right_seq.sv | 111 +++++++++++
 tb/tb_exec_shift_right_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared execute-stage constants: shifter FSM encoding, default
//               shift step and the right-shift ALU funct codes.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } shr_state_e;

    localparam int SHIFT_STEP = 4;

    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;

    // The decoder drives the shifter's arith input from this.
    function automatic logic is_arith_shift(input logic [5:0] funct);
        return (funct == FUNCT_SRA) || (funct == FUNCT_SRAV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_right_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_right_step
// Description : Combinational right shift by n with a selectable fill bit.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_right_step #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   work_i,
    input  logic [SHAMT_W-1:0] n_i,
    input  logic               fill_i,
    output logic [WIDTH-1:0]   shifted_o
);

    // Inverting around a logical shift turns the zero fill into a ones fill.
    assign shifted_o = fill_i ? ~((~work_i) >> n_i) : (work_i >> n_i);

endmodule
`default_nettype wire

// File: rtl/exec_shift_right_seq.sv
`default_nettype none
// ============================================================================
// Module      : exec_shift_right_seq
// Description : Iterative right shifter (SRL/SRA/SRLV/SRAV), STEP bits per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_shift_right_seq
    import exec_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = SHIFT_STEP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    input  logic               flush,
    output logic [WIDTH-1:0]   out,
    output logic               busy,
    output logic               done
);

    localparam logic [31:0] STEP_W = 32'(STEP);

    shr_state_e         state_q;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   out_q;
    logic [SHAMT_W-1:0] rem_q;
    logic               fill_q;
    logic               busy_q;
    logic               done_q;

    logic [SHAMT_W-1:0] n_d;
    logic [SHAMT_W-1:0] rem_d;
    logic [WIDTH-1:0]   work_d;

    // The step is never larger than what remains, so rem cannot underflow.
    always_comb begin
        n_d   = (32'(rem_q) >= STEP_W) ? STEP_W[SHAMT_W-1:0] : rem_q;
        rem_d = rem_q - n_d;
    end

    shift_right_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .work_i    (work_q),
        .n_i       (n_d),
        .fill_i    (fill_q),
        .shifted_o (work_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            if (flush) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_SHIFT: begin
                        work_q <= work_d;
                        rem_q  <= rem_d;
                        if (rem_d == '0) begin
                            out_q   <= work_d;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                        end
                    end
                    default: begin
                        // IDLE and DONE both accept a new request.
                        if (start) begin
                            work_q <= in_data;
                            rem_q  <= shamt;
                            fill_q <= arith & in_data[WIDTH-1];
                            if (shamt == '0) begin
                                out_q   <= in_data;
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_SHIFT;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_shift_right_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_shift_right_seq
// Description : Self-checking bench for exec_shift_right_seq (STEP 1, 4, 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_shift_right_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0]  shamt = '0;
    logic        arith = 1'b0;
    logic        flush = 1'b0;

    logic [31:0] out1, out4, out32;
    logic        busy1, busy4, busy32;
    logic        done1, done4, done32;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;

    always #5 clk = ~clk;

    exec_shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .shamt(shamt),
        .arith(arith), .flush(flush), .out(out4), .busy(busy4), .done(done4));
    exec_shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .shamt(shamt),
        .arith(arith), .flush(flush), .out(out1), .busy(busy1), .done(done1));
    exec_shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .shamt(shamt),
        .arith(arith), .flush(flush), .out(out32), .busy(busy32), .done(done32));

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic a);
        if (a) return 32'($signed(d) >>> s);
        return d >> s;
    endfunction

    function automatic int ceil_div(input logic [4:0] s, input int st);
        return (int'(s) + st - 1) / st;
    endfunction

    // Drives one request; returns just after the accepting edge with start low.
    task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic a);
        @(negedge clk);
        start = 1'b1; in_data = d; shamt = s; arith = a;
        exp_q.push_back(ref_shift(d, s, a));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0; bc = 0;
        while (done4 !== 1'b1 && lat < 60) begin
            if (busy4 === 1'b1) bc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic idle_no_done(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done4 !== 1'b0) seen++;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if ({out4, busy4, done4} !== 34'h0) $display("FAIL reset4 out=%h busy=%b done=%b want 0", out4, busy4, done4); else n_pass++;
        n_checks++; if ({out1, busy1, done1} !== 34'h0) $display("FAIL reset1 out=%h busy=%b done=%b want 0", out1, busy1, done1); else n_pass++;
        n_checks++; if ({out32, busy32, done32} !== 34'h0) $display("FAIL reset32 out=%h busy=%b done=%b want 0", out32, busy32, done32); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_logical();
        int lat, bc;
        issue(32'hF000_0000, 5'd5, 1'b0);
        wait_done(lat, bc);
        last_exp = exp_q.pop_front();
        n_checks++; if (lat != 2) $display("FAIL srl5_latency got %0d want 2", lat); else n_pass++;
        n_checks++; if (bc != 2) $display("FAIL srl5_busy got %0d want 2", bc); else n_pass++;
        n_checks++; if (out4 !== last_exp) $display("FAIL srl5_out got %h want %h", out4, last_exp); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (done4 !== 1'b0) $display("FAIL srl5_done_pulse got %b want 0", done4); else n_pass++;
    endtask

    task automatic test_arith();
        int lat, bc;
        issue(32'hF000_0000, 5'd31, 1'b1);
        wait_done(lat, bc);
        last_exp = exp_q.pop_front();
        n_checks++; if (lat != 8 || bc != 8) $display("FAIL sra31_timing lat=%0d busy=%0d want 8/8", lat, bc); else n_pass++;
        n_checks++; if (out4 !== 32'hFFFF_FFFF) $display("FAIL sra31_neg got %h want ffffffff", out4); else n_pass++;
        issue(32'h7FFF_FFFF, 5'd31, 1'b1);
        wait_done(lat, bc);
        last_exp = exp_q.pop_front();
        n_checks++; if (out4 !== 32'h0) $display("FAIL sra31_pos got %h want 00000000", out4); else n_pass++;
        issue(32'h8000_0000, 5'd31, 1'b0);
        wait_done(lat, bc);
        last_exp = exp_q.pop_front();
        n_checks++; if (out4 !== 32'h1) $display("FAIL srl31 got %h want 00000001", out4); else n_pass++;
    endtask

    task automatic test_zero_back_to_back();
        int lat, bc;
        issue(32'h1234_5678, 5'd0, 1'b0);
        wait_done(lat, bc);
        last_exp = exp_q.pop_front();
        n_checks++; if (lat != 0 || bc != 0) $display("FAIL zero_timing lat=%0d busy=%0d want 0/0", lat, bc); else n_pass++;
        n_checks++; if (out4 !== 32'h1234_5678) $display("FAIL zero_out got %h want 12345678", out4); else n_pass++;
        issue(32'h1234_5678, 5'd8, 1'b0);
        wait_done(lat, bc);
        last_exp = exp_q.pop_front();
        n_checks++; if (lat != 2) $display("FAIL b2b_latency got %0d want 2", lat); else n_pass++;
        n_checks++; if (out4 !== 32'h0012_3456) $display("FAIL b2b_out got %h want 00123456", out4); else n_pass++;
    endtask

    task automatic test_flush();
        int seen;
        issue(32'hCAFE_0000, 5'd16, 1'b0);
        @(posedge clk); #1;
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        void'(exp_q.pop_back());
        n_checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) $display("FAIL flush_state busy=%b done=%b want 0/0", busy4, done4); else n_pass++;
        n_checks++; if (out4 !== last_exp) $display("FAIL flush_out got %h want %h", out4, last_exp); else n_pass++;
        idle_no_done(8, seen);
        n_checks++; if (seen != 0) $display("FAIL flush_no_done got %0d pulses want 0", seen); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int k, seen;
        @(negedge clk);
        start = 1'b1; in_data = 32'hFFFF_0000; shamt = 5'd12; arith = 1'b0;
        exp_q.push_back(ref_shift(32'hFFFF_0000, 5'd12, 1'b0));
        @(posedge clk); #1;
        in_data = 32'h0F0F_0F0F; shamt = 5'd1; arith = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 2;
        while (done4 !== 1'b1 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        last_exp = exp_q.pop_front();
        n_checks++; if (k != 3) $display("FAIL held_start_latency got %0d want 3", k); else n_pass++;
        n_checks++; if (out4 !== last_exp) $display("FAIL held_start_out got %h want %h", out4, last_exp); else n_pass++;
        idle_no_done(6, seen);
        n_checks++; if (seen != 0) $display("FAIL held_start_single_done got %0d extra want 0", seen); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        issue(32'hDEAD_BEEF, 5'd20, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        n_checks++; if (out4 !== 32'h0 || busy4 !== 1'b0 || done4 !== 1'b0) $display("FAIL reset_mid out=%h busy=%b done=%b want 0", out4, busy4, done4); else n_pass++;
        last_exp = '0;
        @(negedge clk); rst_n = 1'b1;
        idle_no_done(8, seen);
        n_checks++; if (seen != 0) $display("FAIL reset_mid_no_done got %0d pulses want 0", seen); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic [4:0]  s;
        logic        a;
        int          l1, l4, l32, k;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        for (int i = 0; i < 24; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            a = 1'($urandom_range(0, 1));
            if (i == 0) begin d = 32'h8000_0001; s = 5'd31; a = 1'b1; end
            if (i == 1) begin d = 32'hA5A5_A5A5; s = 5'd0;  a = 1'b1; end
            if (i == 2) begin d = 32'h9000_0000; s = 5'd1;  a = 1'b1; end
            if (i == 3) begin d = 32'hFFFF_FFFF; s = 5'd4;  a = 1'b0; end
            e = ref_shift(d, s, a);
            issue(d, s, a);
            l1 = -1; l4 = -1; l32 = -1; k = 0;
            while ((l1 < 0 || l4 < 0 || l32 < 0) && k < 60) begin
                if (l1 < 0 && done1 === 1'b1) l1 = k;
                if (l32 < 0 && done32 === 1'b1) l32 = k;
                if (l4 < 0 && done4 === 1'b1) begin
                    l4 = k;
                    last_exp = exp_q.pop_front();
                    n_checks++; if (out4 !== last_exp) $display("FAIL rnd_out4 in=%h sh=%0d ar=%b got %h want %h", d, s, a, out4, last_exp); else n_pass++;
                end
                if (l1 < 0 || l4 < 0 || l32 < 0) begin
                    @(posedge clk); #1;
                    k++;
                end
            end
            if (l4 < 0) void'(exp_q.pop_front());
            n_checks++; if (l4 != ceil_div(s, 4)) $display("FAIL rnd_lat4 sh=%0d got %0d want %0d", s, l4, ceil_div(s, 4)); else n_pass++;
            n_checks++; if (l1 != ceil_div(s, 1)) $display("FAIL rnd_lat1 sh=%0d got %0d want %0d", s, l1, ceil_div(s, 1)); else n_pass++;
            n_checks++; if (l32 != ceil_div(s, 32)) $display("FAIL rnd_lat32 sh=%0d got %0d want %0d", s, l32, ceil_div(s, 32)); else n_pass++;
            n_checks++; if (out1 !== e) $display("FAIL rnd_out1 in=%h sh=%0d ar=%b got %h want %h", d, s, a, out1, e); else n_pass++;
            n_checks++; if (out32 !== e) $display("FAIL rnd_out32 in=%h sh=%0d ar=%b got %h want %h", d, s, a, out32, e); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith();
        test_zero_back_to_back();
        test_flush();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
